// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: op encodings, flag bit positions, skid-stage states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_defs;

   // Op encodings shared with the adder/subtractor and the decoder
   typedef enum logic [1:0] {
      OP_ADD   = 2'd0,
      OP_SUB   = 2'd1,
      OP_LOGIC = 2'd2,
      OP_PASS  = 2'd3
   } op_e;

   // Flag vector layout is {N,Z,C,V}
   localparam int FLAG_W = 4;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Occupancy of the result stage: main entry only, or main plus skid entry
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation from op, operands and ALU result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   op     - ALU op (alu_defs::op_e encoding)
//   a, b   - operands as seen by the adder/subtractor
//   result - ALU result
//   flags  - {N,Z,C,V}
module alu_flag_gen
   import alu_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]        op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [WIDTH-1:0]  result,
   output logic [FLAG_W-1:0] flags
);

   logic msb_a;
   logic msb_b;
   logic msb_r;

   assign msb_a = a[WIDTH-1];
   assign msb_b = b[WIDTH-1];
   assign msb_r = result[WIDTH-1];

   always_comb begin
      flags         = '0;
      flags[FLAG_N] = msb_r;
      flags[FLAG_Z] = (result == '0);
      case (op_e'(op))
         OP_ADD: begin
            // a wrapped sum is smaller than either addend exactly when it carried out
            flags[FLAG_C] = (result < a);
            flags[FLAG_V] = (msb_a == msb_b) && (msb_r != msb_a);
         end
         OP_SUB: begin
            // C means borrow here, not the inverted-carry convention
            flags[FLAG_C] = (a < b);
            flags[FLAG_V] = (msb_a != msb_b) && (msb_r != msb_a);
         end
         default: begin
            flags[FLAG_C] = 1'b0;
            flags[FLAG_V] = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: tags results with flags, 2-entry skid buffer toward writeback.
// Latency: 1 cycle from input accept to out_valid; 1 op/cycle sustained when out_ready=1.
// Backpressure: in_ready is a decode of the state register (low only when both entries are full).
//
// Ports:
//   clk, reset                        - clock, asynchronous active-high reset
//   in_valid/in_ready                 - upstream handshake
//   in_op, in_a, in_b, in_result      - op and data from the adder/subtractor
//   in_rd, in_we                      - writeback destination and enable
//   out_valid/out_ready               - writeback handshake
//   out_result, out_rd, out_we, out_flags - head entry
//   flags_q                           - architectural flags, updated per output handshake
//   retired                           - wrapping count of output handshakes
module alu_result_stage
   import alu_defs::*;
#(
   parameter int WIDTH = 32,
   parameter int RD_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   input  logic [WIDTH-1:0]  in_result,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_result,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_we,
   output logic [FLAG_W-1:0] out_flags,
   output logic [FLAG_W-1:0] flags_q,
   output logic [CNT_W-1:0]  retired
);

   skid_state_e state;
   skid_state_e state_nxt;

   logic              accept;
   logic              drain;
   logic [FLAG_W-1:0] in_flags;

   logic [WIDTH-1:0]  skid_result;
   logic [RD_W-1:0]   skid_rd;
   logic              skid_we;
   logic [FLAG_W-1:0] skid_flags;

   logic load_main_in;
   logic load_main_skid;
   logic load_skid;

   alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .op     (in_op),
      .a      (in_a),
      .b      (in_b),
      .result (in_result),
      .flags  (in_flags)
   );

   assign accept = in_valid && in_ready;
   assign drain  = out_valid && out_ready;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_EMPTY;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (accept) state_nxt = ST_ONE;
         ST_ONE: begin
            if (accept && !drain)      state_nxt = ST_TWO;
            else if (!accept && drain) state_nxt = ST_EMPTY;
         end
         ST_TWO:   if (drain) state_nxt = ST_ONE;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   // Outputs decoded from the state register only, so in_ready never
   // depends combinationally on out_ready
   always_comb begin
      out_valid = (state != ST_EMPTY);
      in_ready  = (state != ST_TWO);
   end

   // The main entry is the output register. New data goes straight into it
   // when it is empty or being vacated with no skid entry waiting; otherwise
   // it parks in the skid entry, which moves forward on the next drain.
   assign load_main_in   = accept && ((state == ST_EMPTY) || ((state == ST_ONE) && drain));
   assign load_skid      = accept && (state == ST_ONE) && !drain;
   assign load_main_skid = drain && (state == ST_TWO);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_result <= '0;
         out_rd     <= '0;
         out_we     <= 1'b0;
         out_flags  <= '0;
      end else if (load_main_in) begin
         out_result <= in_result;
         out_rd     <= in_rd;
         out_we     <= in_we;
         out_flags  <= in_flags;
      end else if (load_main_skid) begin
         out_result <= skid_result;
         out_rd     <= skid_rd;
         out_we     <= skid_we;
         out_flags  <= skid_flags;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_result <= '0;
         skid_rd     <= '0;
         skid_we     <= 1'b0;
         skid_flags  <= '0;
      end else if (load_skid) begin
         skid_result <= in_result;
         skid_rd     <= in_rd;
         skid_we     <= in_we;
         skid_flags  <= in_flags;
      end
   end

   // Every completed handshake retires, including entries with out_we=0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= '0;
         retired <= '0;
      end else if (drain) begin
         flags_q <= out_flags;
         retired <= retired + CNT_W'(1);
      end
   end

endmodule
